nec_bus_ctrl: RTL and testbench
===============================

Name: nec_bus_ctrl

Overview:
- Bus-cycle front end for the NEC V30/V35 pins: decodes ASTB/RDn/WRn/IOn/UBEn into word-wide memory/IO requests and returns read data.
- Sits directly downstream of the system top's NEC pin wiring; drives NEC_READY, the AD output data and the AD output enable.
- Presents a simple req/ack request port upstream of the future DDRAM/BRAM arbiter.
- Samples all NEC control inputs in the system clk domain; NEC_CLK is clk/4.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for NEC control inputs (min 2)
- TIMEOUT_CYCLES, 1024, clk cycles before a stalled request is abandoned (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- nec_ad_in  in  20  AD bus input (pad input side)
- nec_ad_out  out  20  AD bus drive value, {4'h0, rdata}
- nec_ad_oe  out  1  1 = FPGA drives AD[15:0]
- nec_astb  in  1  address strobe
- nec_rdn  in  1  read strobe, active low
- nec_wrn  in  1  write strobe, active low
- nec_ion  in  1  0 = IO cycle, 1 = memory cycle
- nec_uben  in  1  upper byte enable, active low
- nec_ready  out  1  READY to CPU
- mem_req  out  1  request valid, held until ack
- mem_io  out  1  request is an IO cycle
- mem_we  out  1  1 = write
- mem_addr  out  19  word address (A[19:1])
- mem_be  out  2  byte enables {hi, lo}
- mem_wdata  out  16  write data
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  16  read data, valid with mem_ack

Behaviour:
- Reset values: nec_ad_oe=0, nec_ad_out=0, nec_ready=1, mem_req=0, mem_we=0, mem_io=0, mem_addr=0, mem_be=0, mem_wdata=0, state=IDLE. Synchronizers are cleared to the inactive level (astb=0, rdn=wrn=ion=ubn=1).
- ASTB, RDn, WRn, IOn and UBEn pass through SYNC_STAGES flops. AD is not synchronized; it is sampled only when the synchronized strobes guarantee stability.
- Address latch: while astb_s=1, capture addr<=nec_ad_in, ubn, ion on every cycle. The falling edge of astb_s freezes the latch.
- States:
  - IDLE: on astb_s falling edge -> CMD; nec_ready<=0 the same cycle.
  - CMD: when rdn_s=0 -> REQ with we=0. When wrn_s=0 -> REQ with we=1 and mem_wdata<=nec_ad_in[15:0]. If both are low, write wins.
  - REQ: mem_req=1 with all request fields stable until mem_ack. On ack, capture rdata and set nec_ready<=1 -> HOLD.
  - HOLD: for reads, nec_ad_oe=1 and nec_ad_out={4'h0, rdata}. When both rdn_s and wrn_s are high -> IDLE and nec_ad_oe<=0.
- mem_be from {A0, UBEn}: 00 -> 2'b11; 01 -> 2'b01; 10 -> 2'b10; 11 -> 2'b00. For 11, skip REQ, set ready=1 and go to HOLD (no request is issued).
- mem_ack while not in REQ is ignored.
- A new ASTB falling edge in any state other than IDLE is ignored. The protocol guarantees it cannot occur.
- Reset mid-cycle: everything returns to reset values at once, and the outstanding request is dropped. The downstream arbiter must tolerate a dropped request.
- Latency: a read completes in mem_ack+1 cycles after mem_req rises. mem_req rises 1 cycle after rdn_s falls.

Optional Feature:
- NEC_BUS_TIMEOUT_EN defined:
  - A counter runs in REQ. When it reaches TIMEOUT_CYCLES, mem_req drops, rdata<=16'hFFFF, nec_ready<=1, and the block goes to HOLD.
  - Sticky output bus_timeout (1 bit, cleared by reset) is set.
- Undefined: no counter and no bus_timeout port; REQ waits forever.

Decomposition:
- Package nec_bus_pkg:
  - state enum bus_state_t {IDLE, CMD, REQ, HOLD}
  - typedef mem_req_t {io, we, addr[18:0], be[1:0], wdata[15:0]}
  - constant NEC_ADDR_W=20
- Sub-module nec_sync: a parameterized N-bit, SYNC_STAGES-deep synchronizer with a reset value parameter; instantiated once for the 5 control inputs.

Test Plan:
- Memory word read: AD=20'h12344, IOn=1, UBEn=0, RDn low; ack after 5 clk with rdata=16'hBEEF. Expect mem_addr=19'h091A2, be=11, we=0; ready low until ack+1; AD driven 16'hBEEF until RDn high; oe=0 afterwards.
- Odd-byte write: AD=20'h00101, UBEn=0, WRn low with AD[15:0]=16'hAB00. Expect mem_addr=19'h00080, be=10, we=1, wdata=16'hAB00.
- IO low-byte read: IOn=0, AD=20'h00040, UBEn=1. Expect mem_io=1, be=01, mem_addr=19'h00020.
- Reset asserted in REQ. Expect mem_req=0, ready=1 and oe=0 next cycle; the next bus cycle runs normally.
- Stray mem_ack pulse in IDLE, plus the UBEn=1/A0=1 combination. Expect no state change; no request issued and ready stays/returns 1.
- With NEC_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=16, never ack. Expect completion after 16 cycles with AD=16'hFFFF and bus_timeout=1.

Source files
------------

// File: rtl/nec_bus_pkg.sv
// Shared types and helpers for the NEC V30/V35 bus-cycle front end.
// Optional request timeout is enabled with NEC_BUS_TIMEOUT_EN in nec_bus_ctrl.
package nec_bus_pkg;

  localparam int NEC_ADDR_W = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    REQ  = 2'd2,
    HOLD = 2'd3
  } bus_state_t;

  typedef struct packed {
    logic        io;
    logic        we;
    logic [18:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } mem_req_t;

  // {A0, UBEn} -> {hi, lo} byte enables; 2'b00 means no byte is addressed
  function automatic logic [1:0] be_decode(input logic a0, input logic ubn);
    logic [1:0] be;
    case ({a0, ubn})
      2'b00:   be = 2'b11;
      2'b01:   be = 2'b01;
      2'b10:   be = 2'b10;
      default: be = 2'b00;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/nec_sync.sv
// N-bit multi-flop synchronizer with a per-bit reset value.
module nec_sync #(
  parameter int             W       = 5,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [STAGES];

  // Shift chain; reset parks every stage at the inactive level
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/nec_bus_ctrl.sv
// NEC V30/V35 pin decoder: turns ASTB/RDn/WRn cycles into word-wide req/ack requests.
// Define NEC_BUS_TIMEOUT_EN to abandon stalled requests after TIMEOUT_CYCLES and flag bus_timeout.
module nec_bus_ctrl
  import nec_bus_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NEC_ADDR_W-1:0] nec_ad_in,
  output logic [NEC_ADDR_W-1:0] nec_ad_out,
  output logic                  nec_ad_oe,
  input  logic                  nec_astb,
  input  logic                  nec_rdn,
  input  logic                  nec_wrn,
  input  logic                  nec_ion,
  input  logic                  nec_uben,
  output logic                  nec_ready,
  output logic                  mem_req,
  output logic                  mem_io,
  output logic                  mem_we,
  output logic [18:0]           mem_addr,
  output logic [1:0]            mem_be,
  output logic [15:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_rdata
`ifdef NEC_BUS_TIMEOUT_EN
  ,
  output logic                  bus_timeout
`endif
);

  logic [4:0]            sync_q;
  logic                  astb_s, rdn_s, wrn_s, ion_s, ubn_s;
  logic                  astb_prev_q;
  logic                  astb_fall;
  logic [NEC_ADDR_W-1:0] addr_q;
  logic                  ubn_q;
  logic                  ion_q;
  logic [1:0]            be_d;
  bus_state_t            state_q;
  mem_req_t              req_q;

  nec_sync #(
    .W       (5),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (5'b01111)
  ) u_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     ({nec_astb, nec_rdn, nec_wrn, nec_ion, nec_uben}),
    .q_o     (sync_q)
  );

  assign {astb_s, rdn_s, wrn_s, ion_s, ubn_s} = sync_q;
  assign astb_fall = astb_prev_q & ~astb_s;
  assign be_d      = be_decode(addr_q[0], ubn_q);

  // Transparent address latch while the synchronized strobe is high
  always_ff @(posedge clk) begin
    if (reset) begin
      astb_prev_q <= 1'b0;
      addr_q      <= '0;
      ubn_q       <= 1'b1;
      ion_q       <= 1'b1;
    end else begin
      astb_prev_q <= astb_s;
      if (astb_s) begin
        addr_q <= nec_ad_in;
        ubn_q  <= ubn_s;
        ion_q  <= ion_s;
      end
    end
  end

`ifdef NEC_BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             timeout_q;
  assign bus_timeout = timeout_q;
`endif

  // Bus-cycle FSM with all CPU-facing and request outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= '0;
      mem_req    <= 1'b0;
      nec_ready  <= 1'b1;
      nec_ad_oe  <= 1'b0;
      nec_ad_out <= '0;
`ifdef NEC_BUS_TIMEOUT_EN
      tmo_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (astb_fall) begin
            state_q   <= CMD;
            nec_ready <= 1'b0;
          end
        end
        CMD: begin
          // Write wins when both strobes are seen low together
          if (!wrn_s || !rdn_s) begin
            req_q.io   <= ~ion_q;
            req_q.we   <= ~wrn_s;
            req_q.addr <= addr_q[19:1];
            req_q.be   <= be_d;
            if (!wrn_s) begin
              req_q.wdata <= nec_ad_in[15:0];
            end
`ifdef NEC_BUS_TIMEOUT_EN
            tmo_q <= '0;
`endif
            if (be_d == 2'b00) begin
              nec_ready <= 1'b1;
              state_q   <= HOLD;
            end else begin
              mem_req <= 1'b1;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            nec_ready <= 1'b1;
            state_q   <= HOLD;
            if (!req_q.we) begin
              nec_ad_oe  <= 1'b1;
              nec_ad_out <= {4'h0, mem_rdata};
            end
          end
`ifdef NEC_BUS_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            mem_req   <= 1'b0;
            nec_ready <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= HOLD;
            if (!req_q.we) begin
              nec_ad_oe  <= 1'b1;
              nec_ad_out <= {4'h0, 16'hFFFF};
            end
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end
        HOLD: begin
          if (rdn_s && wrn_s) begin
            nec_ad_oe <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_io    = req_q.io;
  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_be    = req_q.be;
  assign mem_wdata = req_q.wdata;

endmodule

// File: tb/tb_nec_bus_ctrl.sv
// Scoreboard bench for nec_bus_ctrl: CPU-side driver, ack responder and request monitor.
module tb_nec_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] nec_ad_in;
  logic [19:0] nec_ad_out;
  logic        nec_ad_oe;
  logic        nec_astb, nec_rdn, nec_wrn, nec_ion, nec_uben;
  logic        nec_ready;
  logic        mem_req, mem_io, mem_we;
  logic [18:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
`ifdef NEC_BUS_TIMEOUT_EN
  logic        bus_timeout;
`endif

  nec_bus_ctrl #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .nec_ad_in  (nec_ad_in),
    .nec_ad_out (nec_ad_out),
    .nec_ad_oe  (nec_ad_oe),
    .nec_astb   (nec_astb),
    .nec_rdn    (nec_rdn),
    .nec_wrn    (nec_wrn),
    .nec_ion    (nec_ion),
    .nec_uben   (nec_uben),
    .nec_ready  (nec_ready),
    .mem_req    (mem_req),
    .mem_io     (mem_io),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
`ifdef NEC_BUS_TIMEOUT_EN
    ,
    .bus_timeout(bus_timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        io;
    logic        we;
    logic [18:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } exp_req_t;

  exp_req_t    exp_q[$];
  logic [15:0] rd_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          no_ack   = 1'b0;
  bit          use_fixed = 1'b0;
  int          fixed_dly = 0;
  logic [15:0] fixed_rd  = 16'h0;
  int          stray_req_n  = 0;
  int          stray_done_n = 0;
  logic        req_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising mem_req is matched against the oldest expected request
  always @(negedge clk) begin : mon
    exp_req_t e;
    if (mem_req && !req_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_req: got addr %h be %b with none expected", mem_addr, mem_be);
      end else begin
        e = exp_q.pop_front();
        check("mem_io",    32'(mem_io),    32'(e.io));
        check("mem_we",    32'(mem_we),    32'(e.we));
        check("mem_addr",  32'(mem_addr),  32'(e.addr));
        check("mem_be",    32'(mem_be),    32'(e.be));
        if (e.we) check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
      end
    end
    req_prev <= mem_req;
  end

  // Downstream responder: acks requests after a delay, or emits stray acks on demand
  initial begin : resp
    int          dly;
    logic [15:0] rd;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (stray_done_n != stray_req_n) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'h5A5A;
        @(negedge clk);
        mem_ack = 1'b0;
        stray_done_n++;
      end else if (mem_req && !no_ack) begin
        dly = use_fixed ? fixed_dly : int'($urandom_range(0, 8));
        rd  = use_fixed ? fixed_rd : 16'($urandom);
        repeat (dly) @(negedge clk);
        check("ready_low_at_ack", 32'(nec_ready), 32'd0);
        check("req_held",         32'(mem_req),   32'd1);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        if (!mem_we) rd_q.push_back(rd);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        check("ready_after_ack", 32'(nec_ready), 32'd1);
        check("req_dropped",     32'(mem_req),   32'd0);
      end
    end
  end

  // Address phase; also records the request the CPU cycle should produce
  task automatic addr_phase(input logic [19:0] ad, input logic ion, input logic ubn,
                            input logic wr, input logic [15:0] wd, output logic [1:0] be);
    exp_req_t e;
    be = {~ubn, ~ad[0]};
    if (be != 2'b00) begin
      e.io = ~ion; e.we = wr; e.addr = ad[19:1]; e.be = be; e.wdata = wd;
      exp_q.push_back(e);
    end
    @(negedge clk);
    nec_ad_in = ad; nec_ion = ion; nec_uben = ubn; nec_astb = 1'b1;
    repeat (4) @(negedge clk);
    nec_astb = 1'b0;
    repeat (4) @(negedge clk);
    check("ready_low_cmd", 32'(nec_ready), 32'd0);
  endtask

  task automatic bus_cycle(input logic [19:0] ad, input logic ion, input logic ubn,
                           input logic wr, input logic [15:0] wd);
    logic [1:0]  be;
    logic [15:0] exp_rd;
    int          t;
    bit          drives;
    addr_phase(ad, ion, ubn, wr, wd, be);
    if (wr) begin
      nec_ad_in = {4'h0, wd};
      nec_wrn   = 1'b0;
    end else begin
      nec_ad_in = 20'($urandom);
      nec_rdn   = 1'b0;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!nec_ready && t < 300);
    check("ready_return", 32'(nec_ready), 32'd1);
    drives = !wr && (be != 2'b00);
    check("oe_in_hold", 32'(nec_ad_oe), 32'(drives));
    if (drives) begin
      exp_rd = (rd_q.size() > 0) ? rd_q.pop_front() : 16'hxxxx;
      check("ad_out_rdata", 32'(nec_ad_out), 32'({4'h0, exp_rd}));
    end
    repeat (2) @(negedge clk);
    nec_rdn = 1'b1;
    nec_wrn = 1'b1;
    repeat (2) @(negedge clk);
    check("oe_until_strobe_sync", 32'(nec_ad_oe), 32'(drives));
    repeat (4) @(negedge clk);
    check("oe_released", 32'(nec_ad_oe), 32'd0);
    check("ready_idle",  32'(nec_ready), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [1:0] be;
    int         t;
    reset = 1'b1;
    nec_ad_in = 20'h0; nec_astb = 1'b0; nec_rdn = 1'b1; nec_wrn = 1'b1;
    nec_ion = 1'b1; nec_uben = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(nec_ready),  32'd1);
    check("rst_req",   32'(mem_req),    32'd0);
    check("rst_oe",    32'(nec_ad_oe),  32'd0);
    check("rst_adout", 32'(nec_ad_out), 32'd0);
    check("rst_fields", 32'({mem_io, mem_we, mem_be, mem_addr}), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Directed memory word read, odd-byte write, IO low-byte read
    use_fixed = 1'b1; fixed_dly = 5; fixed_rd = 16'hBEEF;
    bus_cycle(20'h12344, 1'b1, 1'b0, 1'b0, 16'h0);
    bus_cycle(20'h00101, 1'b1, 1'b0, 1'b1, 16'hAB00);
    fixed_dly = 2; fixed_rd = 16'h00C3;
    bus_cycle(20'h00040, 1'b0, 1'b1, 1'b0, 16'h0);
    use_fixed = 1'b0;

    // Reset while a request is outstanding
    no_ack = 1'b1;
    addr_phase(20'h5_6788, 1'b1, 1'b0, 1'b0, 16'h0, be);
    nec_rdn = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mem_req && t < 50);
    check("req_before_reset", 32'(mem_req), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1; nec_rdn = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_req_dropped", 32'(mem_req),   32'd0);
    check("rst_ready_high",  32'(nec_ready), 32'd1);
    check("rst_oe_low",      32'(nec_ad_oe), 32'd0);
    repeat (4) @(negedge clk);
    no_ack = 1'b0;
    bus_cycle(20'h0_2468, 1'b1, 1'b0, 1'b0, 16'h0);

    // Stray ack in IDLE, then an A0=1/UBEn=1 cycle that addresses no byte
    stray_req_n++;
    repeat (4) @(negedge clk);
    check("stray_ready", 32'(nec_ready), 32'd1);
    check("stray_noreq", 32'(mem_req),   32'd0);
    bus_cycle(20'h0_0777, 1'b1, 1'b1, 1'b0, 16'h0);
    bus_cycle(20'h3_0001, 1'b0, 1'b1, 1'b1, 16'h1234);

    for (int i = 0; i < 40; i++) begin
      bus_cycle(20'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
    end

`ifdef NEC_BUS_TIMEOUT_EN
    no_ack = 1'b1;
    rd_q.push_back(16'hFFFF);
    bus_cycle(20'h0_1000, 1'b1, 1'b0, 1'b0, 16'h0);
    check("bus_timeout_set", 32'(bus_timeout), 32'd1);
    no_ack = 1'b0;
`endif

    repeat (4) @(negedge clk);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
